// File: rtl/immed_pkg.sv
// Shared types and constants for the decode-stage immediate generator.
//   imm_type_e : immediate format tag carried alongside each immediate
//   OPC_*      : RV major opcodes recognised by the decoder
//   imm_pkt_t  : one decoded result (immediate at maximum width, format, illegal flag)
package immed_pkg;

    // Decoder always produces the widest immediate; the pipe keeps the low XLEN bits.
    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        IMM_R  = 3'd0,
        IMM_I  = 3'd1,
        IMM_S  = 3'd2,
        IMM_B  = 3'd3,
        IMM_U  = 3'd4,
        IMM_J  = 3'd5,
        IMM_Z  = 3'd6,
        IMM_SH = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_type_e           imm_type;
        logic                illegal;
    } imm_pkt_t;

endpackage

// File: rtl/immed_gen_pipe_decode.sv
// Combinational immediate decoder.
//   ir  : 32-bit instruction word
//   pkt : immediate sign/zero-extended to XLEN_MAX, its format, illegal flag
module immed_decode
    import immed_pkg::*;
#(
    parameter int SHAMT_W = 5
) (
    input  logic [31:0] ir,
    output imm_pkt_t    pkt
);

    logic [6:0]          opc;
    logic [2:0]          funct3;
    logic                s;
    logic [XLEN_MAX-1:0] imm_i;

    assign opc    = ir[6:0];
    assign funct3 = ir[14:12];
    assign s      = ir[31];
    assign imm_i  = {{(XLEN_MAX-12){s}}, ir[31:20]};

    always_comb begin
        pkt.imm      = '0;
        pkt.imm_type = IMM_R;
        pkt.illegal  = 1'b0;
        if (ir[1:0] != 2'b11) begin
            pkt.illegal = 1'b1;
        end else begin
            case (opc)
                OPC_OPIMM: begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        // Shift amount only; funct7/funct6 above it are not part of the immediate.
                        pkt.imm_type             = IMM_SH;
                        pkt.imm[SHAMT_W-1:0]     = ir[20 +: SHAMT_W];
                    end else begin
                        pkt.imm_type = IMM_I;
                        pkt.imm      = imm_i;
                    end
                end
                OPC_LOAD, OPC_JALR: begin
                    pkt.imm_type = IMM_I;
                    pkt.imm      = imm_i;
                end
                OPC_STORE: begin
                    pkt.imm_type = IMM_S;
                    pkt.imm      = {{(XLEN_MAX-12){s}}, ir[31:25], ir[11:7]};
                end
                OPC_BRANCH: begin
                    pkt.imm_type = IMM_B;
                    pkt.imm      = {{(XLEN_MAX-13){s}}, s, ir[7], ir[30:25], ir[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    pkt.imm_type = IMM_U;
                    pkt.imm      = {{(XLEN_MAX-32){s}}, ir[31:12], 12'b0};
                end
                OPC_JAL: begin
                    pkt.imm_type = IMM_J;
                    pkt.imm      = {{(XLEN_MAX-21){s}}, s, ir[19:12], ir[20], ir[30:21], 1'b0};
                end
                OPC_SYSTEM: begin
                    if (funct3[2]) begin
                        pkt.imm_type = IMM_Z;
                        pkt.imm      = {{(XLEN_MAX-5){1'b0}}, ir[19:15]};
                    end else begin
                        pkt.imm_type = IMM_I;
                        pkt.imm      = imm_i;
                    end
                end
                OPC_OP: begin
                    pkt.imm_type = IMM_R;
                end
                default: begin
                    pkt.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/immed_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer.
//   CLK, RST_N       : clock, async active-low reset
//   FLUSH            : synchronous flush of both entries (and any same-cycle input)
//   IN_VALID/IN_READY: input handshake for IR
//   OUT_VALID/OUT_READY: output handshake for IMM, IMM_TYPE, ILLEGAL
module immed_gen_pipe
    import immed_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     IR,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] IMM,
    output imm_type_e       IMM_TYPE,
    output logic            ILLEGAL
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("immed_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    imm_pkt_t dec_pkt;

    immed_decode #(.SHAMT_W(SHAMT_W)) u_decode (
        .ir  (IR),
        .pkt (dec_pkt)
    );

    generate
        if (XLEN < XLEN_MAX) begin : g_trim
            logic unused_hi;
            assign unused_hi = ^dec_pkt.imm[XLEN_MAX-1:XLEN];
        end
    endgenerate

    logic            main_valid_q, main_valid_d;
    logic [XLEN-1:0] main_imm_q,   main_imm_d;
    imm_type_e       main_type_q,  main_type_d;
    logic            main_ill_q,   main_ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    imm_type_e       skid_type_q,  skid_type_d;
    logic            skid_ill_q,   skid_ill_d;

    logic in_xfer, out_xfer, slot_free;

    // IN_READY comes straight from the skid flop, so OUT_READY never reaches it combinationally.
    assign IN_READY  = !skid_valid_q;
    assign in_xfer   = IN_VALID && !skid_valid_q;
    assign out_xfer  = main_valid_q && OUT_READY;
    assign slot_free = !main_valid_q || OUT_READY;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_type_d  = main_type_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_type_d  = skid_type_q;
        skid_ill_d   = skid_ill_q;
        if (FLUSH) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (out_xfer) begin
                if (skid_valid_q) begin
                    main_imm_d   = skid_imm_q;
                    main_type_d  = skid_type_q;
                    main_ill_d   = skid_ill_q;
                    skid_valid_d = 1'b0;
                end else begin
                    main_valid_d = 1'b0;
                end
            end
            // in_xfer implies skid empty, so this never collides with the skid->main move.
            if (in_xfer) begin
                if (slot_free) begin
                    main_valid_d = 1'b1;
                    main_imm_d   = dec_pkt.imm[XLEN-1:0];
                    main_type_d  = dec_pkt.imm_type;
                    main_ill_d   = dec_pkt.illegal;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_imm_d   = dec_pkt.imm[XLEN-1:0];
                    skid_type_d  = dec_pkt.imm_type;
                    skid_ill_d   = dec_pkt.illegal;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_type_q  <= IMM_R;
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_type_q  <= IMM_R;
            skid_ill_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_type_q  <= main_type_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_type_q  <= skid_type_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign OUT_VALID = main_valid_q;
    assign IMM       = main_imm_q;
    assign IMM_TYPE  = main_type_q;
    assign ILLEGAL   = main_ill_q;

endmodule

// File: tb/tb_immed_gen_pipe.sv
// Directed bench for immed_gen_pipe: one XLEN=32 and one XLEN=64 instance share the input stream.
module tb_immed_gen_pipe;
    import immed_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] ir;
    logic        out_ready;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    imm_type_e   type32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    imm_type_e   type64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    immed_gen_pipe #(.XLEN(32)) dut32 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready32),
        .IR(ir), .OUT_VALID(out_valid32), .OUT_READY(out_ready), .IMM(imm32),
        .IMM_TYPE(type32), .ILLEGAL(illegal32)
    );

    immed_gen_pipe #(.XLEN(64)) dut64 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready64),
        .IR(ir), .OUT_VALID(out_valid64), .OUT_READY(out_ready), .IMM(imm64),
        .IMM_TYPE(type64), .ILLEGAL(illegal64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks a full output word on the XLEN=32 instance.
    task automatic chk_out(input string tag, input logic [31:0] imm_e, input imm_type_e t_e,
                           input logic ill_e);
        chk({tag, ".valid"}, 64'(out_valid32), 64'd1);
        chk({tag, ".imm"},   64'(imm32),       64'(imm_e));
        chk({tag, ".type"},  64'(type32),      64'(t_e));
        chk({tag, ".ill"},   64'(illegal32),   64'(ill_e));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        ir        = 32'hFFF00093;
        out_ready = 1'b1;
        #3;
        chk("rst.valid", 64'(out_valid32), 64'd0);
        chk("rst.imm",   64'(imm32),       64'd0);
        chk("rst.type",  64'(type32),      64'(IMM_R));
        chk("rst.ill",   64'(illegal32),   64'd0);
        chk("rst.ready", 64'(in_ready32),  64'd1);
        tick();
        tick();
        chk("rst.no_xfer", 64'(out_valid32), 64'd0);

        // release reset with the addi still presented; it transfers on the next edge
        rst_n = 1'b1;
        tick();
        chk_out("addi", 32'hFFFFFFFF, IMM_I, 1'b0);
        ir = 32'hFE112E23; tick(); chk_out("sw",   32'hFFFFFFFC, IMM_S,  1'b0);
        ir = 32'hFE000CE3; tick(); chk_out("beq",  32'hFFFFFFF8, IMM_B,  1'b0);
        ir = 32'h0010006F; tick(); chk_out("jal",  32'h00000800, IMM_J,  1'b0);
        ir = 32'h4030D093; tick(); chk_out("srai", 32'h00000003, IMM_SH, 1'b0);
        chk("srai.imm64", imm64, 64'h3);
        ir = 32'h300FD073; tick(); chk_out("csrrwi", 32'h0000001F, IMM_Z, 1'b0);
        ir = 32'h00000000; tick(); chk_out("zero", 32'h0, IMM_R, 1'b1);
        ir = 32'hFFF00091; tick(); chk_out("lowbits", 32'h0, IMM_R, 1'b1);
        ir = 32'h00208033; tick(); chk_out("add", 32'h0, IMM_R, 1'b0);
        ir = 32'h800002B7; tick(); chk_out("lui_neg", 32'h80000000, IMM_U, 1'b0);
        chk("lui_neg.imm64",  imm64,          64'hFFFFFFFF80000000);
        chk("lui_neg.type64", 64'(type64),    64'(IMM_U));
        ir = 32'h123452B7; tick(); chk_out("lui_pos", 32'h12345000, IMM_U, 1'b0);
        chk("lui_pos.imm64",  imm64,          64'h0000000012345000);
        chk("lui_pos.valid64", 64'(out_valid64), 64'd1);

        in_valid = 1'b0;
        tick();
        chk("drain.valid", 64'(out_valid32), 64'd0);

        // Backpressure: A, B accepted, C stalls until the consumer resumes
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ir = 32'h00100093; tick();
        chk_out("bp.A", 32'h1, IMM_I, 1'b0);
        chk("bp.ready_after_A", 64'(in_ready32), 64'd1);
        ir = 32'h00200093; tick();
        chk("bp.ready_after_B", 64'(in_ready32), 64'd0);
        chk("bp.hold_A1", 64'(imm32), 64'h1);
        ir = 32'h00300093; tick();
        chk("bp.ready_stall", 64'(in_ready32), 64'd0);
        chk_out("bp.hold_A2", 32'h1, IMM_I, 1'b0);
        out_ready = 1'b1; tick();
        chk_out("bp.B", 32'h2, IMM_I, 1'b0);
        chk("bp.ready_back", 64'(in_ready32), 64'd1);
        tick();
        chk_out("bp.C", 32'h3, IMM_I, 1'b0);
        in_valid = 1'b0; tick();
        chk("bp.empty", 64'(out_valid32), 64'd0);

        // Flush with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ir = 32'h00100093; tick();
        ir = 32'h00200093; tick();
        chk("fl.full", 64'(in_ready32), 64'd0);
        ir = 32'h00700093; flush = 1'b1; tick();
        chk("fl1.valid", 64'(out_valid32), 64'd0);
        chk("fl1.ready", 64'(in_ready32),  64'd1);
        // Flush while IN_READY=1 with an input presented: it must be dropped
        flush = 1'b0;
        ir = 32'h00100093; tick();
        chk("fl2.pre", 64'(out_valid32), 64'd1);
        ir = 32'h00700093; flush = 1'b1; tick();
        chk("fl2.valid", 64'(out_valid32), 64'd0);
        chk("fl2.ready", 64'(in_ready32),  64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("fl2.never", 64'(out_valid32), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ir = 32'h00500093; tick();
        chk("ar.pre", 64'(out_valid32), 64'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar.valid", 64'(out_valid32), 64'd0);
        chk("ar.imm",   64'(imm32),       64'd0);
        chk("ar.valid64", 64'(out_valid64), 64'd0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        chk("ar.no_replay", 64'(out_valid32), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/immed_gen_pipe.md
Name: immed_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Accepts a full 32-bit instruction over a valid/ready handshake and classifies it by opcode into one immediate format.
- Emits the sign- or zero-extended immediate at XLEN width, together with its format and an illegal flag.
- A 2-entry skid buffer provides full throughput under backpressure, so the block sits between fetch and the register-read/execute stages.

Parameters:
- XLEN, 32, datapath width of IMM. Legal values are 32 and 64; any other value is an elaboration error.
- SHAMT_W, (XLEN==64 ? 6 : 5), shift-amount field width. Derived; do not override.

Ports:
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous reset, active low
- FLUSH  input  1  synchronous pipeline flush
- IN_VALID  input  1  IR is valid this cycle
- IN_READY  output  1  block can accept IR this cycle
- IR  input  32  instruction word
- OUT_VALID  output  1  IMM, IMM_TYPE and ILLEGAL are valid
- OUT_READY  input  1  consumer accepts the output this cycle
- IMM  output  XLEN  generated immediate
- IMM_TYPE  output  3  immed_pkg::imm_type_e (R, I, S, B, U, J, Z, SH)
- ILLEGAL  output  1  opcode not recognised, or IR[1:0] != 2'b11

Behaviour:
- Reset is asynchronous on the RST_N falling edge. While RST_N is low:
  - OUT_VALID=0, IMM=0, IMM_TYPE=R, ILLEGAL=0; skid entry invalid.
  - IN_READY=1, but no transfer occurs while RST_N=0.
- Reset is also allowed mid-transfer: in-flight data is discarded and nothing is replayed.
- Input transfer occurs on IN_VALID & IN_READY. Output transfer occurs on OUT_VALID & OUT_READY.
- Latency: exactly 1 cycle from input transfer to OUT_VALID when no output is stalled.
- Storage is a main (output) register plus one skid register. IN_READY = !skid_valid, driven directly from a flop with no combinational path from OUT_READY.
- Update rules, where "slot free" means the main register is empty or is transferring out this cycle:
  - Input transfer, slot free: load into the main register.
  - Input transfer, slot not free: load into the skid register, so IN_READY=0 next cycle.
  - Output transfer with skid valid: skid moves to main and the skid entry becomes invalid.
  - Simultaneous output transfer, skid valid and input transfer: cannot happen, because IN_READY=0 whenever skid is valid.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- OUT_VALID=1 with OUT_READY=0: IMM, IMM_TYPE and ILLEGAL hold stable until transferred.
- FLUSH=1 at a clock edge:
  - Both entries become invalid.
  - Any input presented in the same cycle is discarded.
  - FLUSH takes priority over every other event.
- Decoding is on IR[6:0]; all immediates are sign-extended from IR[31] to XLEN unless noted:
  - 0010011 OP-IMM: I format, except funct3 001/101, which is SH format. SH: IMM = zero-extended IR[20+SHAMT_W-1:20], so funct7/funct6 bits are excluded.
  - 0000011 LOAD and 1100111 JALR: I format, IR[31:20].
  - 0100011 STORE: S format, {IR[31:25], IR[11:7]}.
  - 1100011 BRANCH: B format, {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - 0110111 LUI and 0010111 AUIPC: U format, {IR[31:12], 12'b0}, then sign-extended to XLEN.
  - 1101111 JAL: J format, {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
  - 1110011 SYSTEM: funct3[2]=1 gives Z format, IMM = zero-extended IR[19:15]; otherwise I format.
  - 0110011 OP: R format, IMM = 0.
- Any other opcode, or IR[1:0] != 2'b11: ILLEGAL=1, IMM_TYPE=R, IMM=0. The instruction still transfers normally.

Decomposition:
- Package immed_pkg holds:
  - imm_type_e enum, 3-bit: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, SH=7.
  - Opcode localparams: OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_OP.
  - Struct imm_pkt_t {imm, imm_type, illegal}, parametrised via XLEN localparam or a wrapper.
- Sub-module immed_decode is purely combinational: IR in, imm_pkt_t out. immed_gen_pipe instantiates it and holds only the skid/handshake logic.

Test Plan:
- XLEN=32, IR=0xFFF00093 (addi -1), OUT_READY=1 -> next cycle OUT_VALID=1, IMM=0xFFFFFFFF, TYPE=I, ILLEGAL=0.
- IR=0xFE112E23 (sw -4), then 0xFE000CE3 (beq -8), then 0x0010006F (jal +2048), back-to-back -> IMM=0xFFFFFFFC/S, 0xFFFFFFF8/B, 0x00000800/J, one per cycle.
- Type coverage:
  - IR=0x4030D093 (srai 3) -> IMM=0x3, TYPE=SH.
  - IR=0x300FD073 (csrrwi 31) -> IMM=0x1F, TYPE=Z.
  - IR=0x00000000 -> ILLEGAL=1, IMM=0.
- XLEN=64, IR=0x800002B7 (lui 0x80000) -> IMM=0xFFFFFFFF80000000, TYPE=U; IR=0x123452B7 -> IMM=0x0000000012345000.
- Backpressure:
  - Stimulus: OUT_READY=0, present 3 valid instructions A, B, C.
  - Required: A and B accepted, IN_READY=0 from the cycle after B, OUT_VALID data stays A.
  - Then raise OUT_READY: outputs A, B, C in order, IN_READY returns to 1.
- Flush and reset:
  - Stimulus: FLUSH with both entries full and IN_VALID=1. Required: OUT_VALID=0 and IN_READY=1 next cycle, and the flushed input never appears.
  - Stimulus: RST_N low mid-stream. Required: OUT_VALID=0 immediately, without waiting for a clock edge.
